register_file_sb: RTL and testbench

- Parametrised multi-read-port register file with one write port, synchronous active-low reset, write-to-read bypass and a per-register pending-write scoreboard.
- Sits in the datapath decode stage. The read ports feed operand latches.
- BUSY tells the hazard/stall logic that a register's value is not yet valid, because a multi-cycle producer such as a load or divide has been issued against it.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/rf_read_port.sv | 51 +++++
 rtl/register_file_sb.sv | 83 ++++++++
 tb/tb_register_file_sb.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults, word type and address range helper for the register file.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
// Contents: RF_WIDTH/RF_DEPTH/RF_NUM_RD defaults, rf_word_t, in_range().
package regfile_pkg;

  localparam int RF_WIDTH  = 32;
  localparam int RF_DEPTH  = 32;
  localparam int RF_NUM_RD = 2;

  typedef logic [RF_WIDTH-1:0] rf_word_t;

  // DEPTH need not be a power of two, so every address must be checked
  // against the real register count, not just the address width.
  function automatic logic in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: write-first bypass, range check, data/BUSY mux.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the port always answers.
// Ports: ra_i read address; we_i/wa_i/wd_i live write port for bypass;
//        regs_i/sb_i registered storage and scoreboard; rd_o data; busy_o pending flag.
// Build option: REGFILE_ZERO_REG_EN makes address 0 read as 0 and never busy.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic [AW-1:0]             ra_i,
  input  logic                      we_i,
  input  logic [AW-1:0]             wa_i,
  input  logic [WIDTH-1:0]          wd_i,
  input  logic [DEPTH-1:0][WIDTH-1:0] regs_i,
  input  logic [DEPTH-1:0]          sb_i,
  output logic [WIDTH-1:0]          rd_o,
  output logic                      busy_o
);

  logic hit;

  always_comb begin
    rd_o   = '0;
    busy_o = 1'b0;
    hit    = in_range(32'(ra_i), DEPTH);
`ifdef REGFILE_ZERO_REG_EN
    // Hardwired zero wins even over a same-cycle bypassed write to r0.
    if (ra_i == '0) hit = 1'b0;
`endif
    if (hit) begin
      if (we_i && (wa_i == ra_i)) begin
        // The value arriving now is the valid one, so nothing is pending.
        rd_o = wd_i;
      end else begin
        // Explicit compare-mux keeps non-power-of-two depths free of
        // out-of-bounds indexing.
        for (int i = 0; i < DEPTH; i++) begin
          if (ra_i == AW'(i)) begin
            rd_o   = regs_i[i];
            busy_o = sb_i[i];
          end
        end
      end
    end
  end

endmodule

// File: rtl/register_file_sb.sv
// Multi-read-port register file with one write port, write-first bypass and a pending-write scoreboard.
// Latency: reads zero cycles; writes, scoreboard updates and ANY_BUSY one cycle.
// Backpressure: none; BUSY/ANY_BUSY inform the external stall logic.
// Ports: CLK, RESETn (sync active-low); RA/RD/BUSY packed per read port;
//        WE/WA/WD write port; SB_SET/SB_ADDR mark pending; ANY_BUSY = OR of scoreboard.
// Build option: REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int DEPTH  = RF_DEPTH,
  parameter int NUM_RD = RF_NUM_RD,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                    CLK,
  input  logic                    RESETn,
  input  logic [NUM_RD*AW-1:0]    RA,
  output logic [NUM_RD*WIDTH-1:0] RD,
  output logic [NUM_RD-1:0]       BUSY,
  input  logic                    WE,
  input  logic [AW-1:0]           WA,
  input  logic [WIDTH-1:0]        WD,
  input  logic                    SB_SET,
  input  logic [AW-1:0]           SB_ADDR,
  output logic                    ANY_BUSY
);

  logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]            sb_q, sb_d;
  logic                        wr_ok, set_ok;

  always_comb begin
    wr_ok  = WE && in_range(32'(WA), DEPTH);
    set_ok = SB_SET && in_range(32'(SB_ADDR), DEPTH);
`ifdef REGFILE_ZERO_REG_EN
    wr_ok  = wr_ok && (WA != '0);
    set_ok = set_ok && (SB_ADDR != '0);
`endif
    regs_d = regs_q;
    sb_d   = sb_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_ok && (WA == AW'(i))) begin
        regs_d[i] = WD;
        sb_d[i]   = 1'b0;
      end
      // Applied after the write clear: a newly issued producer outranks
      // the writeback landing in the same cycle.
      if (set_ok && (SB_ADDR == AW'(i))) begin
        sb_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      regs_q <= '0;
      sb_q   <= '0;
    end else begin
      regs_q <= regs_d;
      sb_q   <= sb_d;
    end
  end

  // Registered view only; same-cycle set/clear shows up next cycle.
  assign ANY_BUSY = |sb_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    rf_read_port #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_rd (
      .ra_i   (RA[p*AW +: AW]),
      .we_i   (WE),
      .wa_i   (WA),
      .wd_i   (WD),
      .regs_i (regs_q),
      .sb_i   (sb_q),
      .rd_o   (RD[p*WIDTH +: WIDTH]),
      .busy_o (BUSY[p])
    );
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb with DEPTH=20 and NUM_RD=3.
// Directed scenarios first, then randomized traffic against an array model.
// Honours REGFILE_ZERO_REG_EN in the reference model.
module tb_register_file_sb;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 20;
  localparam int NUM_RD = 3;
  localparam int AW     = 5;

  logic                    CLK = 1'b0;
  logic                    RESETn;
  logic [NUM_RD*AW-1:0]    RA;
  logic [NUM_RD*WIDTH-1:0] RD;
  logic [NUM_RD-1:0]       BUSY;
  logic                    WE;
  logic [AW-1:0]           WA;
  logic [WIDTH-1:0]        WD;
  logic                    SB_SET;
  logic [AW-1:0]           SB_ADDR;
  logic                    ANY_BUSY;

  always #5 CLK = ~CLK;

  register_file_sb #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD)
  ) dut (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .RA       (RA),
    .RD       (RD),
    .BUSY     (BUSY),
    .WE       (WE),
    .WA       (WA),
    .WD       (WD),
    .SB_SET   (SB_SET),
    .SB_ADDR  (SB_ADDR),
    .ANY_BUSY (ANY_BUSY)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: plain arrays indexed by register number.
  logic [WIDTH-1:0] m_reg [DEPTH];
  logic             m_sb  [DEPTH];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic zero_hw(input int a);
`ifdef REGFILE_ZERO_REG_EN
    return a == 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] exp_rd(input int a);
    if (a >= DEPTH || zero_hw(a)) return '0;
    if (WE && int'(WA) == a) return WD;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (a >= DEPTH || zero_hw(a)) return 1'b0;
    if (WE && int'(WA) == a) return 1'b0;
    return m_sb[a];
  endfunction

  function automatic logic exp_any();
    logic r = 1'b0;
    for (int i = 0; i < DEPTH; i++) r |= m_sb[i];
    return r;
  endfunction

  task automatic check_ports(input string tag);
    for (int p = 0; p < NUM_RD; p++) begin
      int a = int'(RA[p*AW +: AW]);
      chk($sformatf("%s rd%0d a%0d", tag, p, a), 64'(RD[p*WIDTH +: WIDTH]), 64'(exp_rd(a)));
      chk($sformatf("%s busy%0d a%0d", tag, p, a), 64'(BUSY[p]), 64'(exp_busy(a)));
    end
    chk({tag, " any_busy"}, 64'(ANY_BUSY), 64'(exp_any()));
  endtask

  // Advance one clock: update the model from the inputs sampled at the edge,
  // then return at the following negedge so the caller can drive new inputs.
  task automatic tick();
    @(posedge CLK);
    if (!RESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_reg[i] = '0;
        m_sb[i]  = 1'b0;
      end
    end else begin
      if (WE && int'(WA) < DEPTH && !zero_hw(int'(WA))) begin
        m_reg[int'(WA)] = WD;
        m_sb[int'(WA)]  = 1'b0;
      end
      if (SB_SET && int'(SB_ADDR) < DEPTH && !zero_hw(int'(SB_ADDR)))
        m_sb[int'(SB_ADDR)] = 1'b1;
    end
    @(negedge CLK);
  endtask

  task automatic set_ra(input int p, input int a);
    RA[p*AW +: AW] = AW'(a);
  endtask

  task automatic idle();
    WE     = 1'b0;
    SB_SET = 1'b0;
  endtask

  initial begin
    RESETn = 1'b0; WE = 1'b0; WA = '0; WD = '0;
    SB_SET = 1'b0; SB_ADDR = '0; RA = '0;
    @(negedge CLK);
    tick();
    RESETn = 1'b1;
    #1 check_ports("reset");
    chk("reset rd0 const", 64'(RD[WIDTH-1:0]), 64'h0);

    // Reset flush discards data and pending producers.
    WE = 1'b1; WA = 5'd5; WD = 32'hDEADBEEF; SB_SET = 1'b1; SB_ADDR = 5'd7;
    tick();
    idle();
    set_ra(0, 5); set_ra(1, 7);
    #1 chk("pre-flush rd r5", 64'(RD[WIDTH-1:0]), 64'hDEADBEEF);
    chk("pre-flush busy r7", 64'(BUSY[1]), 64'h1);
    RESETn = 1'b0;
    tick();
    RESETn = 1'b1;
    #1 chk("flush rd r5", 64'(RD[WIDTH-1:0]), 64'h0);
    chk("flush busy r7", 64'(BUSY[1]), 64'h0);
    chk("flush any_busy", 64'(ANY_BUSY), 64'h0);

    // Write-first bypass, then the stored value.
    WE = 1'b1; WA = 5'd3; WD = 32'h12345678; set_ra(0, 3);
    #1 chk("bypass rd0", 64'(RD[WIDTH-1:0]), 64'h12345678);
    tick();
    idle();
    #1 chk("bypass held rd0", 64'(RD[WIDTH-1:0]), 64'h12345678);

    // Scoreboard lifecycle on r9.
    SB_SET = 1'b1; SB_ADDR = 5'd9; set_ra(1, 9);
    #1 chk("sb set cycle busy", 64'(BUSY[1]), 64'h0);
    chk("sb set cycle any", 64'(ANY_BUSY), 64'h0);
    tick();
    idle();
    #1 chk("sb busy r9", 64'(BUSY[1]), 64'h1);
    chk("sb any_busy", 64'(ANY_BUSY), 64'h1);
    WE = 1'b1; WA = 5'd9; WD = 32'hA5A5A5A5;
    #1 chk("sb wb cycle busy", 64'(BUSY[1]), 64'h0);
    chk("sb wb cycle rd", 64'(RD[WIDTH +: WIDTH]), 64'hA5A5A5A5);
    tick();
    idle();
    #1 chk("sb after wb busy", 64'(BUSY[1]), 64'h0);
    chk("sb after wb rd", 64'(RD[WIDTH +: WIDTH]), 64'hA5A5A5A5);
    chk("sb after wb any", 64'(ANY_BUSY), 64'h0);

    // Same-cycle write and set on r4: data lands, set wins.
    WE = 1'b1; WA = 5'd4; WD = 32'hCAFEF00D; SB_SET = 1'b1; SB_ADDR = 5'd4;
    tick();
    idle();
    set_ra(2, 4);
    #1 chk("collide rd r4", 64'(RD[2*WIDTH +: WIDTH]), 64'hCAFEF00D);
    chk("collide busy r4", 64'(BUSY[2]), 64'h1);

    // All ports on the same register.
    WE = 1'b1; WA = 5'd2; WD = 32'h55;
    tick();
    idle();
    set_ra(0, 2); set_ra(1, 2); set_ra(2, 2);
    #1 for (int p = 0; p < NUM_RD; p++)
      chk($sformatf("multi rd%0d", p), 64'(RD[p*WIDTH +: WIDTH]), 64'h55);

    // Out-of-range address 25: reads zero, write and set ignored.
    WE = 1'b1; WA = 5'd25; WD = 32'hFFFF_0000; SB_SET = 1'b1; SB_ADDR = 5'd25;
    set_ra(0, 25);
    #1 chk("oor bypass rd0", 64'(RD[WIDTH-1:0]), 64'h0);
    chk("oor bypass busy0", 64'(BUSY[0]), 64'h0);
    tick();
    idle();
    #1 chk("oor rd0", 64'(RD[WIDTH-1:0]), 64'h0);
    for (int a = 0; a < DEPTH; a += NUM_RD) begin
      for (int p = 0; p < NUM_RD; p++) set_ra(p, (a + p) % DEPTH);
      #1 check_ports("oor sweep");
    end

    // Register 0 with write and set in one cycle.
    WE = 1'b1; WA = 5'd0; WD = 32'hFFFFFFFF; SB_SET = 1'b1; SB_ADDR = 5'd0;
    set_ra(0, 0);
`ifdef REGFILE_ZERO_REG_EN
    #1 chk("zero bypass rd", 64'(RD[WIDTH-1:0]), 64'h0);
    tick();
    idle();
    #1 chk("zero rd", 64'(RD[WIDTH-1:0]), 64'h0);
    chk("zero busy", 64'(BUSY[0]), 64'h0);
`else
    #1 chk("r0 bypass rd", 64'(RD[WIDTH-1:0]), 64'hFFFFFFFF);
    tick();
    idle();
    #1 chk("r0 rd", 64'(RD[WIDTH-1:0]), 64'hFFFFFFFF);
    chk("r0 busy", 64'(BUSY[0]), 64'h1);
`endif

    // Randomized traffic, including out-of-range addresses and rare resets.
    for (int n = 0; n < 400; n++) begin
      RESETn  = ($urandom_range(0, 59) != 0);
      WE      = ($urandom_range(0, 1) == 1);
      WA      = AW'($urandom_range(0, 23));
      WD      = $urandom;
      SB_SET  = ($urandom_range(0, 2) == 0);
      SB_ADDR = AW'($urandom_range(0, 23));
      for (int p = 0; p < NUM_RD; p++)
        set_ra(p, (p == 0 && $urandom_range(0, 3) == 0) ? int'(WA) : int'($urandom_range(0, 23)));
      #1 check_ports("rand");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
